ex: RTL and testbench
=====================

// Module: ex
// PURPOSE
//  EX stage, directly downstream of ID/EX. Consumes alusel/aluop, two operands, waddr and wreg.
//  Executes logic and shift ops combinationally.
//  Executes DIV/DIVU with an iterative 32-step restoring divider and writes HI/LO.
//  Its wreg_o/waddr_o/wdata_o feed ID's EX forwarding path and the EX/MEM register.
//  stallreq_o holds the pipeline control for the duration of a divide.
// PARAMETERS
//  DATA_W   32  operand/result width
//  CNT_W    6   iteration counter width; must hold DATA_W
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-low (RstEnable = 1'b0)
//  alusel_i     in   3       result class: NOP/LOGIC/SHIFT/ARITH
//  aluop_i      in   8       op: AND/OR/XOR/NOR/SLL/SRL/SRA/DIV/DIVU/NOP
//  reg1_data_i  in   DATA_W  op1; shift source; dividend
//  reg2_data_i  in   DATA_W  op2; shift amount in [4:0]; divisor
//  waddr_i      in   5       destination GPR
//  wreg_i       in   1       GPR write enable
//  flush_i      in   1       abort an in-flight divide
//  waddr_o      out  5       = waddr_i, combinational
//  wreg_o       out  1       wreg_i; forced WriteDisable for DIV/DIVU
//  wdata_o      out  DATA_W  logic/shift result; ZeroWord for NOP/DIV classes
//  hilo_we_o    out  1       HI/LO write strobe, one cycle
//  hi_o         out  DATA_W  remainder
//  lo_o         out  DATA_W  quotient
//  stallreq_o   out  1       hold PC/IF/ID/ID-EX; inject bubble into EX/MEM
// BEHAVIOUR
//  Reset (rst=0, async):
//   - divider FSM in IDLE; counter 0; latched operands 0.
//   - hilo_we_o=0, stallreq_o=0, hi_o=lo_o=0.
//   - wdata_o=0, wreg_o=0, waddr_o=0.
//  Logic/shift:
//   - zero latency; no state touched.
//   - shifts use reg2[4:0]; SRA replicates reg1[31]; NOR = ~(a|b).
//  Divider FSM (div_unit), states IDLE, BUSY, DONE:
//   IDLE -> BUSY
//    - on DIV/DIVU with divisor!=0.
//    - latch |a| and |b| (signed) or raw a and b (DIVU); latch sign flags; cnt=0.
//   IDLE -> DONE
//    - on DIV/DIVU with divisor==0.
//    - result lo=32'hFFFF_FFFF, hi=dividend.
//   BUSY (each cycle)
//    - one restoring step: shift {rem,quo} left; subtract if rem>=divisor; cnt++.
//    - cnt==31 -> DONE (32 steps).
//   DONE -> IDLE
//    - hilo_we_o=1 for exactly this cycle.
//    - signed fix-up: quotient negated if signs differ; remainder takes dividend sign.
//   INT_MIN / -1
//    - yields lo=32'h8000_0000, hi=0; no special casing.
//  stallreq_o (combinational):
//   - 1 while a DIV/DIVU is present and state!=DONE.
//   - Nonzero divisor: 33 stall cycles (IDLE + 32 BUSY); released in DONE.
//   - Zero divisor: 1 stall cycle.
//  Back-to-back divides:
//   - DONE always returns to IDLE.
//   - The next DIV, seen in the following cycle, starts fresh.
//  flush_i:
//   - flush_i=1 in BUSY or DONE -> IDLE next edge; no hilo_we_o; stallreq_o=0 that cycle.
//   - Flush beats DONE.
//  Inputs are held stable by the stall; the FSM still computes only from latched operands.
//  Reset mid-divide: immediate IDLE; outputs as for reset.
// STRUCTURE
//  defines.v additions:
//   - ALU_DIV_OP, ALU_DIVU_OP, ALU_RES_ARITH.
//   - DivIdle/DivBusy/DivDone state encodings.
//   - Existing RstEnable, ZeroWord, WriteEnable, WriteDisable.
//  One sub-module, div_unit:
//   - FSM, counter, datapath and sign fix-up.
//   - start/signed/a/b/flush in; busy/done/quo/rem out.
//  ex contains the combinational op mux and stall glue only.
// TESTING
//  - OR 0x0000_FF00, 0x0F0F_0000, waddr 3, wreg 1 -> wdata 0x0F0F_FF00, wreg 1, waddr 3, same cycle.
//  - SRA reg1=0x8000_0000, reg2=4 -> 0xF800_0000; SRL -> 0x0800_0000; SLL by 31 of 1 -> 0x8000_0000.
//  - DIVU 100/7 -> stallreq 33 cycles; DONE: lo=14, hi=2, hilo_we 1 cycle; wreg_o 0 throughout.
//  - DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
//  - DIV 0x8000_0000/-1 -> lo=0x8000_0000, hi=0.
//  - DIVU 5/0 -> 1 stall cycle, then lo=0xFFFF_FFFF, hi=5.
//  - Flush/reset abort:
//    - start DIV, flush_i at BUSY cycle 10 -> no hilo_we, stallreq 0 next cycle, IDLE.
//    - repeat with rst=0 mid-BUSY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared widths, ALU op/class encodings and divider state type for the EX stage.
package ex_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned ALUSEL_W   = 3;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned SHAMT_W    = 5;

    localparam logic [ALUSEL_W-1:0] ALU_RES_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] ALU_RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] ALU_RES_SHIFT = 3'b010;
    localparam logic [ALUSEL_W-1:0] ALU_RES_ARITH = 3'b100;

    localparam logic [ALUOP_W-1:0] ALU_NOP_OP  = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] ALU_AND_OP  = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] ALU_OR_OP   = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] ALU_XOR_OP  = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] ALU_NOR_OP  = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] ALU_SLL_OP  = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] ALU_SRL_OP  = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] ALU_SRA_OP  = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] ALU_DIV_OP  = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] ALU_DIVU_OP = 8'b0001_1011;

    localparam logic RST_ENABLE    = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Two's-complement magnitude; INT_MIN maps to itself, which is correct as unsigned.
    function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (ZERO_WORD - v) : v;
    endfunction

endpackage

// File: rtl/ex_if.sv
// ID/EX-side inputs and EX result/stall outputs of the execute stage.
interface ex_if;
    import ex_pkg::*;

    logic [ALUSEL_W-1:0]   alusel_i;
    logic [ALUOP_W-1:0]    aluop_i;
    logic [DATA_W-1:0]     reg1_data_i;
    logic [DATA_W-1:0]     reg2_data_i;
    logic [REG_ADDR_W-1:0] waddr_i;
    logic                  wreg_i;
    logic                  flush_i;
    logic [REG_ADDR_W-1:0] waddr_o;
    logic                  wreg_o;
    logic [DATA_W-1:0]     wdata_o;
    logic                  hilo_we_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  stallreq_o;

    modport master (
        output alusel_i, aluop_i, reg1_data_i, reg2_data_i, waddr_i, wreg_i, flush_i,
        input  waddr_o, wreg_o, wdata_o, hilo_we_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  alusel_i, aluop_i, reg1_data_i, reg2_data_i, waddr_i, wreg_i, flush_i,
        output waddr_o, wreg_o, wdata_o, hilo_we_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative 32-step restoring divider for DIV/DIVU with sign fix-up.
module ex_div_unit
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_flush,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quo,
    output logic [DATA_W-1:0] o_rem
);

    div_state_e        r_state;
    div_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              w_zero_div;
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W-1:0] w_diff;
    logic              w_ge;

    assign w_zero_div = (i_b == ZERO_WORD);
    assign w_rem_sh   = {r_rem, r_quo[DATA_W-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
    assign w_diff     = w_rem_sh[DATA_W-1:0] - r_dvs;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            DIV_IDLE: if (i_start) w_state_nxt = w_zero_div ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (i_flush) begin
                    w_state_nxt = DIV_IDLE;
                end else if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
    end

    // Operand latch on start, then one shift/compare/subtract step per BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            unique case (r_state)
                DIV_IDLE: begin
                    if (i_start) begin
                        r_cnt   <= '0;
                        r_rem   <= w_zero_div ? i_a : ZERO_WORD;
                        r_quo   <= w_zero_div ? '1 : (i_signed ? f_abs(i_a) : i_a);
                        r_dvs   <= i_signed ? f_abs(i_b) : i_b;
                        r_neg_q <= i_signed & ~w_zero_div & (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
                        r_neg_r <= i_signed & ~w_zero_div & i_a[DATA_W-1];
                    end
                end
                DIV_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_quo <= {r_quo[DATA_W-2:0], w_ge};
                    r_rem <= w_ge ? w_diff : w_rem_sh[DATA_W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_busy = (r_state == DIV_BUSY);
        o_done = (r_state == DIV_DONE);
        o_quo  = ZERO_WORD;
        o_rem  = ZERO_WORD;
        if (r_state == DIV_DONE) begin
            o_quo = r_neg_q ? (ZERO_WORD - r_quo) : r_quo;
            o_rem = r_neg_r ? (ZERO_WORD - r_rem) : r_rem;
        end
    end

endmodule

// File: rtl/ex.sv
// EX stage: combinational logic/shift result mux, divider hookup and pipeline stall glue.
module ex
    import ex_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);

    logic               w_is_div;
    logic               w_signed;
    logic               w_start;
    logic               w_busy;
    logic               w_done;
    logic [DATA_W-1:0]  w_quo;
    logic [DATA_W-1:0]  w_rem;
    logic [SHAMT_W-1:0] w_shamt;
    logic [DATA_W-1:0]  w_logic;
    logic [DATA_W-1:0]  w_shift;
    logic [DATA_W-1:0]  w_wdata;

    assign w_is_div = (bus.aluop_i == ALU_DIV_OP) || (bus.aluop_i == ALU_DIVU_OP);
    assign w_signed = (bus.aluop_i == ALU_DIV_OP);
    assign w_start  = w_is_div & ~w_busy & ~w_done & ~bus.flush_i;
    assign w_shamt  = bus.reg2_data_i[SHAMT_W-1:0];

    ex_div_unit u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_signed (w_signed),
        .i_a      (bus.reg1_data_i),
        .i_b      (bus.reg2_data_i),
        .i_flush  (bus.flush_i),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_quo    (w_quo),
        .o_rem    (w_rem)
    );

    always_comb begin
        w_logic = ZERO_WORD;
        w_shift = ZERO_WORD;
        case (bus.aluop_i)
            ALU_AND_OP: w_logic = bus.reg1_data_i & bus.reg2_data_i;
            ALU_OR_OP:  w_logic = bus.reg1_data_i | bus.reg2_data_i;
            ALU_XOR_OP: w_logic = bus.reg1_data_i ^ bus.reg2_data_i;
            ALU_NOR_OP: w_logic = ~(bus.reg1_data_i | bus.reg2_data_i);
            ALU_SLL_OP: w_shift = bus.reg1_data_i << w_shamt;
            ALU_SRL_OP: w_shift = bus.reg1_data_i >> w_shamt;
            ALU_SRA_OP: w_shift = DATA_W'($signed(bus.reg1_data_i) >>> w_shamt);
            default: begin
            end
        endcase
    end

    always_comb begin
        w_wdata = ZERO_WORD;
        case (bus.alusel_i)
            ALU_RES_LOGIC: w_wdata = w_logic;
            ALU_RES_SHIFT: w_wdata = w_shift;
            default:       w_wdata = ZERO_WORD;
        endcase
    end

    // Everything reads as zero while reset is asserted; a flush drops both the stall and the HI/LO write.
    always_comb begin
        bus.waddr_o    = '0;
        bus.wreg_o     = WRITE_DISABLE;
        bus.wdata_o    = ZERO_WORD;
        bus.hilo_we_o  = 1'b0;
        bus.hi_o       = ZERO_WORD;
        bus.lo_o       = ZERO_WORD;
        bus.stallreq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            bus.waddr_o    = bus.waddr_i;
            bus.wreg_o     = w_is_div ? WRITE_DISABLE : bus.wreg_i;
            bus.wdata_o    = w_wdata;
            bus.hilo_we_o  = w_done & ~bus.flush_i;
            bus.hi_o       = w_rem;
            bus.lo_o       = w_quo;
            bus.stallreq_o = w_is_div & ~w_done & ~bus.flush_i;
        end
    end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the EX stage: directed and random ALU/divide steps against a behavioural model.
module tb_ex;
    import ex_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    ex_if u_if ();

    ex u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] ones;
        sh   = int'(b % 32);
        ones = 32'hFFFF_FFFF;
        case (op)
            ALU_AND_OP: return a & b;
            ALU_OR_OP:  return a | b;
            ALU_XOR_OP: return a ^ b;
            ALU_NOR_OP: return ~(a | b);
            ALU_SLL_OP: return a << sh;
            ALU_SRL_OP: return a >> sh;
            ALU_SRA_OP: return (a >> sh) | ((a >= 32'h8000_0000) ? ~(ones >> sh) : 32'h0);
            default:    return 32'h0;
        endcase
    endfunction

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa, input logic we);
        u_if.alusel_i    = sel;
        u_if.aluop_i     = op;
        u_if.reg1_data_i = a;
        u_if.reg2_data_i = b;
        u_if.waddr_i     = wa;
        u_if.wreg_i      = we;
        u_if.flush_i     = 1'b0;
    endtask

    task automatic drive_nop();
        drive(ALU_RES_NOP, ALU_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic apply_alu(input string tag, input logic [2:0] sel, input logic [7:0] op,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa, input logic we);
        logic [31:0] exp;
        @(negedge clk);
        drive(sel, op, a, b, wa, we);
        exp = (sel == ALU_RES_LOGIC || sel == ALU_RES_SHIFT) ? ref_alu(op, a, b) : 32'h0;
        #1;
        chk({tag, ".wdata"}, u_if.wdata_o, exp);
        chk({tag, ".wreg"}, 32'(u_if.wreg_o), 32'(we));
        chk({tag, ".waddr"}, 32'(u_if.waddr_o), 32'(wa));
        chk({tag, ".stall"}, 32'(u_if.stallreq_o), 32'h0);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] eq;
        logic [31:0] er;
        int          stalls;
        bit          wreg_seen;
        bit          we_early;
        ref_div(a, b, sgn, eq, er);
        stalls    = 0;
        wreg_seen = 1'b0;
        we_early  = 1'b0;
        @(negedge clk);
        drive(ALU_RES_ARITH, sgn ? ALU_DIV_OP : ALU_DIVU_OP, a, b, 5'($urandom_range(1, 31)), 1'b1);
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            wreg_seen = wreg_seen | u_if.wreg_o;
            if (!u_if.stallreq_o) break;
            we_early = we_early | u_if.hilo_we_o;
            stalls++;
            @(negedge clk);
        end
        chk({tag, ".stalls"}, 32'(stalls), (b == 32'h0) ? 32'd1 : 32'd33);
        chk({tag, ".we_early"}, 32'(we_early), 32'h0);
        chk({tag, ".wreg"}, 32'(wreg_seen), 32'h0);
        chk({tag, ".hilo_we"}, 32'(u_if.hilo_we_o), 32'h1);
        chk({tag, ".lo"}, u_if.lo_o, eq);
        chk({tag, ".hi"}, u_if.hi_o, er);
        @(negedge clk);
        drive_nop();
        #1;
        chk({tag, ".we_one_cycle"}, 32'(u_if.hilo_we_o), 32'h0);
    endtask

    initial begin
        logic [7:0] ops [7];
        logic [7:0] op;
        logic [31:0] db;
        bit          we_seen;

        ops = '{ALU_AND_OP, ALU_OR_OP, ALU_XOR_OP, ALU_NOR_OP, ALU_SLL_OP, ALU_SRL_OP, ALU_SRA_OP};
        n_chk = 0;
        n_err = 0;
        clk   = 1'b0;
        rst   = 1'b0;
        drive(ALU_RES_ARITH, ALU_DIV_OP, 32'd50, 32'd3, 5'd7, 1'b1);
        #3;
        chk("rst.stall", 32'(u_if.stallreq_o), 32'h0);
        chk("rst.hilo_we", 32'(u_if.hilo_we_o), 32'h0);
        chk("rst.hi", u_if.hi_o, 32'h0);
        chk("rst.lo", u_if.lo_o, 32'h0);
        chk("rst.wdata", u_if.wdata_o, 32'h0);
        chk("rst.wreg", 32'(u_if.wreg_o), 32'h0);
        chk("rst.waddr", 32'(u_if.waddr_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive_nop();

        apply_alu("or", ALU_RES_LOGIC, ALU_OR_OP, 32'h0000_FF00, 32'h0F0F_0000, 5'd3, 1'b1);
        apply_alu("sra", ALU_RES_SHIFT, ALU_SRA_OP, 32'h8000_0000, 32'd4, 5'd4, 1'b1);
        apply_alu("srl", ALU_RES_SHIFT, ALU_SRL_OP, 32'h8000_0000, 32'd4, 5'd5, 1'b1);
        apply_alu("sll31", ALU_RES_SHIFT, ALU_SLL_OP, 32'h1, 32'd31, 5'd6, 1'b1);
        apply_alu("nor", ALU_RES_LOGIC, ALU_NOR_OP, 32'hF0F0_1234, 32'h0000_FFFF, 5'd9, 1'b0);
        apply_alu("nop", ALU_RES_NOP, ALU_NOP_OP, 32'hDEAD_BEEF, 32'h1234_5678, 5'd1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 6)];
            apply_alu("rnd_alu",
                      (op == ALU_SLL_OP || op == ALU_SRL_OP || op == ALU_SRA_OP) ? ALU_RES_SHIFT : ALU_RES_LOGIC,
                      op, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        run_div("divu_100_7", 32'd100, 32'd7, 1'b0);
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_div("divu_5_0", 32'd5, 32'd0, 1'b0);
        run_div("div_neg_0", 32'hFFFF_FF00, 32'd0, 1'b1);
        run_div("b2b", 32'd1000, 32'd10, 1'b0);

        // Flush at BUSY step 10: stall drops immediately and no HI/LO write ever follows.
        @(negedge clk);
        drive(ALU_RES_ARITH, ALU_DIV_OP, 32'd1000, 32'd3, 5'd2, 1'b1);
        for (int i = 0; i < 11; i++) @(negedge clk);
        u_if.flush_i = 1'b1;
        #1;
        chk("flush.stall", 32'(u_if.stallreq_o), 32'h0);
        chk("flush.hilo_we", 32'(u_if.hilo_we_o), 32'h0);
        we_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_nop();
            #1;
            we_seen = we_seen | u_if.hilo_we_o | u_if.stallreq_o;
        end
        chk("flush.after", 32'(we_seen), 32'h0);
        run_div("post_flush", 32'd1000, 32'd3, 1'b1);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        drive(ALU_RES_ARITH, ALU_DIVU_OP, 32'd12345, 32'd17, 5'd11, 1'b1);
        for (int i = 0; i < 6; i++) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst.stall", 32'(u_if.stallreq_o), 32'h0);
        chk("mrst.hilo_we", 32'(u_if.hilo_we_o), 32'h0);
        chk("mrst.hi", u_if.hi_o, 32'h0);
        chk("mrst.lo", u_if.lo_o, 32'h0);
        chk("mrst.wdata", u_if.wdata_o, 32'h0);
        chk("mrst.wreg", 32'(u_if.wreg_o), 32'h0);
        chk("mrst.waddr", 32'(u_if.waddr_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive_nop();
        run_div("post_rst", 32'd12345, 32'd17, 1'b0);

        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0:       db = 32'h0;
                1:       db = 32'($urandom_range(1, 15));
                2:       db = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: db = $urandom;
            endcase
            run_div("rnd_div", $urandom, db, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
